fetch_queue_stage: RTL and testbench

- Parametrised successor to the single-register fetch stage: decouples instruction fetch from decode through a prefetch queue.
- Issues sequential requests to a synchronous instruction memory with 1-cycle read latency, and buffers returned words with their PCs.
- Presents queue entries to decode under a valid/stall handshake.
- Flushes on a redirect from the execute stage (jump/branch).

---
 rtl/fetch_queue_stage_pkg.sv | 14 +
 rtl/fetch_queue_stage_if.sv | 30 +++
 rtl/fetch_queue_stage_fifo.sv | 73 +++++++
 rtl/fetch_queue_stage.sv | 122 ++++++++++++
 tb/tb_fetch_queue_stage.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_stage_pkg.sv
// Shared types and constants for the fetch queue stage slice.
package fetch_pkg;

  localparam int unsigned FETCH_DATA_WIDTH = 32;
  localparam logic [FETCH_DATA_WIDTH-1:0] FETCH_RESET_PC = '0;
  localparam int unsigned FETCH_PC_STEP = 4;

  // One buffered fetch: the address it was fetched from and the returned word.
  typedef struct packed {
    logic [FETCH_DATA_WIDTH-1:0] pc;
    logic [FETCH_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_stage_if.sv
// Fetch stage bus: instruction memory port, execute redirect and decode handshake.
interface fetch_queue_stage_if
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FETCH_DATA_WIDTH
);

  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  stall_in;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_instr;

  // Fetch stage side.
  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
    input  imem_rdata, stall_in, redirect_valid, redirect_pc
  );

  // Memory / decode / execute side.
  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
    output imem_rdata, stall_in, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_queue_stage_fifo.sv
// Synchronous FIFO of fetch entries with flush; pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  entry_t                 push_data_i,
  output entry_t                 head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  // Next pointer/count state; flush empties the queue and overrides push/pop.
  always_comb begin
    do_push = push_i && !flush_i;
    do_pop  = pop_i && !flush_i && (count_q != '0);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PTR_W'(1);
      if (do_pop)  head_d = head_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset since the count gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[tail_q] <= push_data_i;
  end

  // Head view and status flags.
  always_comb begin
    head_o  = mem_q[head_q];
    count_o = count_q;
    empty_o = (count_q == '0);
    full_o  = (count_q == CNT_W'(DEPTH));
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Prefetching fetch stage: issues sequential reads to a 1-cycle instruction
// memory, buffers returned words with their PCs and hands them to decode.
// Optional macro FETCH_QUEUE_PERF_COUNTERS_EN adds saturating perf counters.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = FETCH_DATA_WIDTH,
  parameter int unsigned           QUEUE_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = DATA_WIDTH'(FETCH_RESET_PC),
  parameter int unsigned           PC_STEP     = FETCH_PC_STEP
) (
  input  logic                clock,
  input  logic                reset,
  fetch_queue_stage_if.master bus
`ifdef FETCH_QUEUE_PERF_COUNTERS_EN
  ,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_flushes,
  output logic [31:0]         perf_full_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] req_pc_q;
  logic                  inflight_q;
  logic                  squash_q;
  logic                  issue, push, pop;
  logic [CNT_W-1:0]      count;
  logic [CNT_W:0]        occupancy;
  logic                  empty, full;
  entry_t                push_entry, head_entry;

  // Issue/credit decision: queued plus in-flight words never exceed the depth,
  // so every returning word is guaranteed a slot.
  always_comb begin
    occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
    issue      = !reset && !bus.redirect_valid && (occupancy < (CNT_W+1)'(QUEUE_DEPTH));
    push       = inflight_q && !squash_q && !bus.redirect_valid;
    pop        = !empty && !bus.stall_in && !bus.redirect_valid;
    push_entry = '{pc: req_pc_q, instr: bus.imem_rdata};
    pc_d       = pc_q;
    if (bus.redirect_valid) pc_d = {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
    else if (issue)         pc_d = pc_q + DATA_WIDTH'(PC_STEP);
  end

  // Fetch PC, return tracking and squash of a response made stale by a redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      squash_q   <= bus.redirect_valid;
      if (issue) req_pc_q <= pc_q;
    end
  end

  fetch_fifo #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (bus.redirect_valid),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (push_entry),
    .head_o      (head_entry),
    .count_o     (count),
    .empty_o     (empty),
    .full_o      (full)
  );

  // Memory request and decode-side view of the queue head (zero when empty).
  always_comb begin
    bus.imem_req  = issue;
    bus.imem_addr = pc_q;
    bus.out_valid = !empty;
    bus.out_pc    = empty ? '0 : head_entry.pc;
    bus.out_instr = empty ? '0 : head_entry.instr;
  end

  // A push into a full queue without a matching pop means credit accounting broke.
  always_ff @(posedge clock) begin
    if (!reset) assert (!(push && full && !pop));
  end

`ifdef FETCH_QUEUE_PERF_COUNTERS_EN
  logic [31:0] perf_stall_q, perf_flush_q, perf_full_q;

  // Saturating event counters: stalled head, redirects, full-queue cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_full_q  <= '0;
    end else begin
      if (!empty && bus.stall_in && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      if (bus.redirect_valid && (perf_flush_q != '1))     perf_flush_q <= perf_flush_q + 32'd1;
      if (full && (perf_full_q != '1))                     perf_full_q  <= perf_full_q + 32'd1;
    end
  end

  // Counter outputs.
  always_comb begin
    perf_stall_cycles = perf_stall_q;
    perf_flushes      = perf_flush_q;
    perf_full_cycles  = perf_full_q;
  end
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_queue_stage;
  import fetch_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset;

  int unsigned assert_count = 0;
  int unsigned fail_count   = 0;

  fetch_queue_stage_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FETCH_QUEUE_PERF_COUNTERS_EN
  logic [31:0] perf_stall_cycles, perf_flushes, perf_full_cycles;
  int unsigned m_stall, m_flush, m_full;
`endif

  fetch_queue_stage #(
    .DATA_WIDTH  (DW),
    .QUEUE_DEPTH (DEPTH),
    .RESET_PC    (32'h0),
    .PC_STEP     (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_QUEUE_PERF_COUNTERS_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes),
    .perf_full_cycles  (perf_full_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model state.
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  bit          m_known = 1'b0;

  // Memory model state.
  bit          mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  bit          scramble = 1'b0;

  // Captured DUT outputs of the most recent cycle.
  logic        cap_req, cap_valid;
  logic [31:0] cap_addr, cap_pc, cap_instr;

  function automatic logic [31:0] word(input logic [31:0] addr);
    if (scramble) return {addr[15:0], addr[31:16]} ^ 32'hC0DE_F00D;
    return addr;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cycle(input bit rst, input bit stl, input bit rdv, input logic [31:0] rpc);
    bit          e_req, e_valid;
    logic [31:0] e_pc, e_instr, rdata;
    ent_t        ne;
    reset              = rst;
    bus.stall_in       = stl;
    bus.redirect_valid = rdv;
    bus.redirect_pc    = rpc;
    rdata              = mem_pend ? word(mem_addr) : $urandom();
    bus.imem_rdata     = rdata;
    #1;
    cap_req   = bus.imem_req;
    cap_addr  = bus.imem_addr;
    cap_valid = bus.out_valid;
    cap_pc    = bus.out_pc;
    cap_instr = bus.out_instr;

    e_valid = (mq.size() != 0);
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    e_instr = e_valid ? mq[0].instr : 32'h0;
    e_req   = !rst && !rdv && ((mq.size() + int'(m_pend)) < DEPTH);

    if (m_known) begin
      check("imem_req", 32'(cap_req), 32'(e_req));
      if (e_req) check("imem_addr", cap_addr, m_pc);
      check("out_valid", 32'(cap_valid), 32'(e_valid));
      check("out_pc", cap_pc, e_pc);
      check("out_instr", cap_instr, e_instr);
`ifdef FETCH_QUEUE_PERF_COUNTERS_EN
      check("perf_stall_cycles", perf_stall_cycles, m_stall);
      check("perf_flushes", perf_flushes, m_flush);
      check("perf_full_cycles", perf_full_cycles, m_full);
`endif
    end

    if (rst) begin
      mq.delete();
      m_pc    = 32'h0;
      m_pend  = 1'b0;
      m_known = 1'b1;
`ifdef FETCH_QUEUE_PERF_COUNTERS_EN
      m_stall = 0; m_flush = 0; m_full = 0;
`endif
    end else begin
`ifdef FETCH_QUEUE_PERF_COUNTERS_EN
      if (e_valid && stl)       m_stall++;
      if (rdv)                  m_flush++;
      if (mq.size() == DEPTH)   m_full++;
`endif
      if (rdv) begin
        mq.delete();
        m_pend = 1'b0;
        m_pc   = rpc & 32'hFFFF_FFFC;
      end else begin
        if (e_valid && !stl) void'(mq.pop_front());
        if (m_pend) begin
          ne.pc    = m_pend_pc;
          ne.instr = rdata;
          mq.push_back(ne);
        end
        m_pend = e_req;
        if (e_req) begin
          m_pend_pc = m_pc;
          m_pc      = m_pc + 32'd4;
        end
      end
    end

    mem_pend = cap_req;
    mem_addr = cap_addr;
    @(negedge clock);
  endtask

  task automatic idle(input int n, input bit stl);
    for (int i = 0; i < n; i++) cycle(1'b0, stl, 1'b0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] drained [5];
    bit          seen;
    int          stall_pct;
    bit          rst_r, stl_r, rdv_r;
    logic [31:0] rpc_r;

    reset              = 1'b1;
    bus.stall_in       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_rdata     = '0;
    @(negedge clock);

    // Reset state and startup latency, memory returns word = address.
    scramble = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("reset_out_valid", 32'(cap_valid), 32'd0);
    check("reset_out_pc", cap_pc, 32'h0);
    check("reset_imem_req", 32'(cap_req), 32'd0);
    idle(1, 1'b0);
    check("c0_req", 32'(cap_req), 32'd1);
    check("c0_addr", cap_addr, 32'h0);
    idle(1, 1'b0);
    check("c1_valid", 32'(cap_valid), 32'd0);
    idle(1, 1'b0);
    check("c2_valid", 32'(cap_valid), 32'd1);
    check("c2_pc", cap_pc, 32'h0);
    check("c2_instr", cap_instr, 32'h0);
    idle(1, 1'b0);
    check("c3_pc", cap_pc, 32'h4);
    check("c3_instr", cap_instr, 32'h4);
    idle(1, 1'b0);
    check("c4_pc", cap_pc, 32'h8);
    idle(4, 1'b0);

    // Stall from cycle 2 until the queue fills, then drain in order.
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    idle(2, 1'b0);
    idle(8, 1'b1);
    check("full_req_dropped", 32'(cap_req), 32'd0);
    check("full_head_pc", cap_pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b0);
      drained[i] = cap_pc;
      if (i == 1) check("resume_addr", cap_addr, 32'h10);
    end
    check("drain0", drained[0], 32'h0);
    check("drain1", drained[1], 32'h4);
    check("drain2", drained[2], 32'h8);
    check("drain3", drained[3], 32'hC);
    check("drain4", drained[4], 32'h10);

    // Redirect with three queued, one in flight, and a pop+push in the same cycle.
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    idle(2, 1'b0);
    idle(2, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h103);
    check("redir_cycle_valid", 32'(cap_valid), 32'd1);
    idle(1, 1'b0);
    check("redir_next_valid", 32'(cap_valid), 32'd0);
    check("redir_target_addr", cap_addr, 32'h100);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      idle(1, 1'b0);
      if (cap_valid) begin
        seen = 1'b1;
        check("redir_first_pc", cap_pc, 32'h100);
      end
    end
    if (!seen) check("redir_first_valid_timeout", 32'd0, 32'd1);
    idle(3, 1'b0);

    // PC wrap at the top of the address space.
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    idle(1, 1'b0);
    check("wrap_addr0", cap_addr, 32'hFFFF_FFFC);
    idle(1, 1'b0);
    check("wrap_addr1", cap_addr, 32'h0);
    check("wrap_req1", 32'(cap_req), 32'd1);
    idle(3, 1'b0);

    // Reset while full.
    idle(8, 1'b1);
    check("prereset_full_noreq", 32'(cap_req), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    idle(1, 1'b0);
    check("postreset_valid", 32'(cap_valid), 32'd0);
    check("postreset_addr", cap_addr, 32'h0);
    idle(2, 1'b0);
    check("postreset_first_pc", cap_pc, 32'h0);

`ifdef FETCH_QUEUE_PERF_COUNTERS_EN
    // Five stalled-with-valid cycles and two redirects.
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    idle(2, 1'b0);
    idle(5, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h200);
    cycle(1'b0, 1'b0, 1'b1, 32'h300);
    idle(2, 1'b0);
    check("perf_stall_5", perf_stall_cycles, 32'd5);
    check("perf_flush_2", perf_flushes, 32'd2);
`endif

    // Randomized traffic against the model.
    scramble = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      stall_pct = ((i / 256) % 2 == 1) ? 80 : 20;
      rst_r = ($urandom_range(0, 199) == 0);
      stl_r = ($urandom_range(0, 99) < stall_pct);
      rdv_r = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 3) == 0) rpc_r = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                           rpc_r = $urandom();
      cycle(rst_r, stl_r, rdv_r, rpc_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
